// File: rtl/led_switch_io.sv
// led_switch_io: memory-mapped LED store / switch+button load responder.
// Ports: clk, rst (sync, active-high); addr/wdata store address and data;
//   led_ctrl (IO store select), switch_ctrl (IO load select);
//   switch_raw/btn_raw asynchronous board inputs; io_rdata 16-bit load data;
//   led 24 registered LEDs; btn_pending sticky button-press flag.
// Macro SWITCH_DEBOUNCE_EN: when defined, switches and button are debounced
//   for DEB_CYCLES stable cycles; otherwise the stable state is the second
//   synchroniser stage (2-cycle latency).
module led_switch_io #(
  parameter int          DEB_CYCLES = 500000,
  parameter logic [31:0] LED_BASE   = 32'hFFFF_FC60,
  parameter logic [31:0] SW_BASE    = 32'hFFFF_FC70
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        led_ctrl,
  input  logic        switch_ctrl,
  input  logic [23:0] switch_raw,
  input  logic        btn_raw,
  output logic [15:0] io_rdata,
  output logic [23:0] led,
  output logic        btn_pending
);
  logic [24:0] sync1_q;
  logic [23:0] sw_q, sw_d, led_q, led_d;
  logic        btn_q, btn_d, btn_prev_q, btn_pending_q, btn_pending_d;
  logic        rd_btn;
  logic        unused_w;
  assign unused_w = ^{wdata[31:16], DEB_CYCLES > 1};
  always_ff @(posedge clk)
    sync1_q <= rst ? '0 : {btn_raw, switch_raw};
`ifdef SWITCH_DEBOUNCE_EN
  localparam int            CW   = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);
  logic [24:0]   sync2_q;
  logic [23:0]   sw_cand_q;
  logic          btn_cand_q;
  logic [CW-1:0] sw_cnt_q, sw_cnt_d, btn_cnt_q, btn_cnt_d;
  // A changed sample restarts the count; the count saturates at CMAX, and the
  // candidate is committed on every edge it stays saturated and unchanged.
  always_comb begin
    sw_cnt_d  = (sync2_q[23:0] != sw_cand_q) ? '0 : (sw_cnt_q == CMAX) ? sw_cnt_q : sw_cnt_q + 1'b1;
    sw_d      = (sync2_q[23:0] == sw_cand_q && sw_cnt_q == CMAX) ? sw_cand_q : sw_q;
    btn_cnt_d = (sync2_q[24] != btn_cand_q) ? '0 : (btn_cnt_q == CMAX) ? btn_cnt_q : btn_cnt_q + 1'b1;
    btn_d     = (sync2_q[24] == btn_cand_q && btn_cnt_q == CMAX) ? btn_cand_q : btn_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync2_q    <= '0;
      sw_cand_q  <= '0;
      btn_cand_q <= 1'b0;
      sw_cnt_q   <= '0;
      btn_cnt_q  <= '0;
    end else begin
      sync2_q    <= sync1_q;
      sw_cand_q  <= sync2_q[23:0];
      btn_cand_q <= sync2_q[24];
      sw_cnt_q   <= sw_cnt_d;
      btn_cnt_q  <= btn_cnt_d;
    end
  end
`else
  // The stable registers act as the second synchroniser stage.
  always_comb begin
    sw_d  = sync1_q[23:0];
    btn_d = sync1_q[24];
  end
`endif
  assign rd_btn = switch_ctrl && addr == SW_BASE + 32'd4;
  always_comb begin
    led_d = !led_ctrl ? led_q :
            (addr == LED_BASE)         ? {led_q[23:16], wdata[15:0]} :
            (addr == LED_BASE + 32'd2) ? {wdata[7:0], led_q[15:0]} : led_q;
    // A new debounced rising edge overrides a same-cycle read-clear.
    btn_pending_d = (btn_q & ~btn_prev_q) | (btn_pending_q & ~rd_btn);
    io_rdata = !switch_ctrl ? 16'h0000 :
               (addr == SW_BASE)         ? sw_q[15:0] :
               (addr == SW_BASE + 32'd2) ? {8'h00, sw_q[23:16]} :
               (addr == SW_BASE + 32'd4) ? {15'h0, btn_pending_q} : 16'h0000;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q          <= '0;
      btn_q         <= 1'b0;
      btn_prev_q    <= 1'b0;
      btn_pending_q <= 1'b0;
      led_q         <= '0;
    end else begin
      sw_q          <= sw_d;
      btn_q         <= btn_d;
      btn_prev_q    <= btn_q;
      btn_pending_q <= btn_pending_d;
      led_q         <= led_d;
    end
  end
  assign led         = led_q;
  assign btn_pending = btn_pending_q;
endmodule

// File: tb/tb_led_switch_io.sv
// tb_led_switch_io: directed self-checking bench for led_switch_io (DEB_CYCLES=4).
module tb_led_switch_io;
`ifdef SWITCH_DEBOUNCE_EN
  localparam int SW_LAT  = 7;
  localparam int BTN_SET = 8;
`else
  localparam int SW_LAT  = 2;
  localparam int BTN_SET = 3;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        led_ctrl = 1'b0;
  logic        switch_ctrl = 1'b0;
  logic [23:0] switch_raw = '0;
  logic        btn_raw = 1'b0;
  logic [15:0] io_rdata;
  logic [23:0] led;
  logic        btn_pending;
  int checks = 0;
  int passes = 0;
  int fails  = 0;
  led_switch_io #(.DEB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .led_ctrl(led_ctrl),
    .switch_ctrl(switch_ctrl), .switch_raw(switch_raw), .btn_raw(btn_raw),
    .io_rdata(io_rdata), .led(led), .btn_pending(btn_pending)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [15:0] exp);
    addr = a;
    switch_ctrl = 1'b1;
    #1;
    chk(tag, {16'h0, io_rdata}, {16'h0, exp});
    switch_ctrl = 1'b0;
  endtask
  initial begin
    step(2);
    chk("rst_led", {8'h0, led}, 32'h0);
    chk("rst_pending", {31'h0, btn_pending}, 32'h0);
    rd_chk("rst_rd_fc70", 32'hFFFF_FC70, 16'h0000);
    rst = 1'b0;
    rd_chk("rst_rd_fc74", 32'hFFFF_FC74, 16'h0000);
    rd_chk("rst_rd_fc60", 32'hFFFF_FC60, 16'h0000);
    rd_chk("rst_rd_fc72", 32'hFFFF_FC72, 16'h0000);
    led_ctrl = 1'b1;
    addr = 32'hFFFF_FC60; wdata = 32'h0000_A5C3; step(1);
    chk("led_lo", {8'h0, led}, 32'h0000_A5C3);
    addr = 32'hFFFF_FC62; wdata = 32'h0000_007E; step(1);
    chk("led_hi", {8'h0, led}, 32'h007E_A5C3);
    addr = 32'hFFFF_FC64; wdata = 32'hFFFF_FFFF; step(1);
    chk("led_unmapped", {8'h0, led}, 32'h007E_A5C3);
    led_ctrl = 1'b0;
    addr = 32'hFFFF_FC60; wdata = 32'h0000_1111; step(1);
    chk("led_no_ctrl", {8'h0, led}, 32'h007E_A5C3);
    rd_chk("rd_no_ctrl_unmapped", 32'hFFFF_FC78, 16'h0000);
    switch_raw = 24'h12ABCD;
    step(SW_LAT - 1);
    rd_chk("sw_before_lat", 32'hFFFF_FC70, 16'h0000);
    step(1);
    rd_chk("sw_at_lat", 32'hFFFF_FC70, 16'hABCD);
    step(10 - SW_LAT);
    rd_chk("sw_lo", 32'hFFFF_FC70, 16'hABCD);
    rd_chk("sw_hi", 32'hFFFF_FC72, 16'h0012);
    addr = 32'hFFFF_FC70;
    #1;
    chk("sw_ctrl_low", {16'h0, io_rdata}, 32'h0);
`ifdef SWITCH_DEBOUNCE_EN
    switch_raw = 24'h000000; step(2);
    switch_raw = 24'h12ABCD; step(3);
    rd_chk("glitch_mid_lo", 32'hFFFF_FC70, 16'hABCD);
    step(7);
    rd_chk("glitch_lo", 32'hFFFF_FC70, 16'hABCD);
    rd_chk("glitch_hi", 32'hFFFF_FC72, 16'h0012);
`else
    switch_raw = 24'h000000; step(1);
    switch_raw = 24'h12ABCD;
    rd_chk("glitch_pre", 32'hFFFF_FC70, 16'hABCD);
    step(1);
    rd_chk("glitch_seen_lo", 32'hFFFF_FC70, 16'h0000);
    rd_chk("glitch_seen_hi", 32'hFFFF_FC72, 16'h0000);
    step(1);
    rd_chk("glitch_gone", 32'hFFFF_FC70, 16'hABCD);
`endif
    btn_raw = 1'b1;
    step(BTN_SET - 1);
    chk("btn_before_set", {31'h0, btn_pending}, 32'h0);
    step(1);
    chk("btn_set", {31'h0, btn_pending}, 32'h1);
    rd_chk("btn_rd1", 32'hFFFF_FC74, 16'h0001);
    addr = 32'hFFFF_FC74; switch_ctrl = 1'b1; step(1);
    switch_ctrl = 1'b0;
    chk("btn_cleared", {31'h0, btn_pending}, 32'h0);
    rd_chk("btn_rd0", 32'hFFFF_FC74, 16'h0000);
    step(4);
    chk("btn_no_reset", {31'h0, btn_pending}, 32'h0);
    btn_raw = 1'b0; step(12);
    btn_raw = 1'b1; step(BTN_SET - 1);
    rd_chk("race_pre", 32'hFFFF_FC74, 16'h0000);
    addr = 32'hFFFF_FC74; switch_ctrl = 1'b1; step(1);
    switch_ctrl = 1'b0;
    chk("race_set_wins", {31'h0, btn_pending}, 32'h1);
    addr = 32'hFFFF_FC74; switch_ctrl = 1'b1; step(1);
    switch_ctrl = 1'b0;
    chk("race_then_clear", {31'h0, btn_pending}, 32'h0);
`ifdef SWITCH_DEBOUNCE_EN
    switch_raw = 24'h00FFFF; step(4);
    rst = 1'b1; step(1);
    rst = 1'b0;
    rd_chk("rstmid_now", 32'hFFFF_FC70, 16'h0000);
    step(6);
    rd_chk("rstmid_hold", 32'hFFFF_FC70, 16'h0000);
    step(1);
    rd_chk("rstmid_recommit", 32'hFFFF_FC70, 16'hFFFF);
`else
    switch_raw = 24'h00FFFF; step(1);
    rst = 1'b1; step(1);
    rst = 1'b0;
    rd_chk("rst_clears_sw", 32'hFFFF_FC70, 16'h0000);
    step(2);
    rd_chk("sw_after_rst", 32'hFFFF_FC70, 16'hFFFF);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
